// File: rtl/ep_script_player.sv
// Script sequencer: replays stored wire/trigger/wait commands into the endpoint fabric; writes only in IDLE.
// Each entry costs one FETCH cycle plus its timed phases; no input backpressure, refused writes set wr_rejected.
module ep_script_player #(
    parameter int N_WIRE      = 6,
    parameter int N_TRIG      = 2,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int WIRE_PRE    = 2,
    parameter int WIRE_SETTLE = 6,
    parameter int TRIG_PRE    = 5,
    parameter int TRIG_POST   = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_wr_en,
    input  logic [2+4+DATA_W-1:0]      cmd_wr_data,
    input  logic                       clear,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       loop_en,
    output logic [N_WIRE*DATA_W-1:0]   wire_out,
    output logic [N_TRIG*DATA_W-1:0]   trig_out,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH):0]     cmd_count,
    output logic                       wr_rejected
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [4:0] NW_C = 5'(N_WIRE);
    localparam logic [4:0] NT_C = 5'(N_TRIG);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_WPRE, S_WSET, S_TPRE, S_TPULSE, S_TPOST, S_WAIT, S_FIN
    } state_t;

    state_t                     state_q, state_d;
    logic [CW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]              count_q, count_d;
    logic [DATA_W-1:0]          cnt_q, cnt_d;
    logic [3:0]                 chan_q, chan_d;
    logic [DATA_W-1:0]          pay_q, pay_d;
    logic [N_WIRE*DATA_W-1:0]   wire_q, wire_d;
    logic                       rej_q, rej_d;
    logic                       wr_ok;
    logic [2+4+DATA_W-1:0]      mem [DEPTH];

    logic [2+4+DATA_W-1:0]      entry;
    logic [1:0]                 f_op;
    logic [3:0]                 f_chan;
    logic [DATA_W-1:0]          f_pay;
    logic [CW-1:0]              next_ptr, adv_ptr;

    assign entry  = mem[rd_ptr_q[AW-1:0]];
    assign f_op   = entry[DATA_W+5:DATA_W+4];
    assign f_chan = entry[DATA_W+3:DATA_W];
    assign f_pay  = entry[DATA_W-1:0];
    // Wrapping at decode time makes an end-of-script loop restart cost no extra cycle.
    assign next_ptr = rd_ptr_q + 1'b1;
    assign adv_ptr  = (loop_en && next_ptr == count_q) ? '0 : next_ptr;

    always_comb begin
        count_d = count_q;
        rej_d   = rej_q;
        wr_ok   = 1'b0;
        if (clear && state_q == S_IDLE) begin
            count_d = '0;
            rej_d   = 1'b0;
        end else if (cmd_wr_en) begin
            if (state_q == S_IDLE && count_q < DEPTH_C) begin
                wr_ok   = 1'b1;
                count_d = count_q + 1'b1;
            end else begin
                rej_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        chan_d   = chan_q;
        pay_d    = pay_q;
        wire_d   = wire_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_FETCH;
                    rd_ptr_d = '0;
                end
            end
            S_FETCH: begin
                if (rd_ptr_q == count_q || f_op == 2'd3) begin
                    if (loop_en && count_q != '0) rd_ptr_d = '0;
                    else                          state_d  = S_FIN;
                end else begin
                    rd_ptr_d = adv_ptr;
                    chan_d   = f_chan;
                    pay_d    = f_pay;
                    case (f_op)
                        2'd0: if ({1'b0, f_chan} < NW_C) begin
                            state_d = S_WPRE;
                            cnt_d   = DATA_W'(WIRE_PRE - 1);
                        end
                        2'd1: if ({1'b0, f_chan} < NT_C) begin
                            state_d = S_TPRE;
                            cnt_d   = DATA_W'(TRIG_PRE - 1);
                        end
                        default: if (f_pay != '0) begin
                            state_d = S_WAIT;
                            cnt_d   = f_pay - 1'b1;
                        end
                    endcase
                end
            end
            S_WPRE: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_WSET;
                    cnt_d   = DATA_W'(WIRE_SETTLE - 1);
                    for (int k = 0; k < N_WIRE; k++)
                        if (chan_q == 4'(k)) wire_d[k*DATA_W +: DATA_W] = pay_q;
                end
            end
            S_WSET, S_TPOST, S_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = S_FETCH;
            end
            S_TPRE: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = S_TPULSE;
            end
            S_TPULSE: begin
                state_d = S_TPOST;
                cnt_d   = DATA_W'(TRIG_POST - 1);
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cnt_q    <= '0;
            chan_q   <= '0;
            pay_q    <= '0;
            wire_q   <= '0;
            rej_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cnt_q    <= cnt_d;
            chan_q   <= chan_d;
            pay_q    <= pay_d;
            wire_q   <= wire_d;
            rej_q    <= rej_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok && !reset) mem[count_q[AW-1:0]] <= cmd_wr_data;
    end

    // Trigger masks exist only during TPULSE, so abort and reset clear them via the state alone.
    always_comb begin
        trig_out = '0;
        if (state_q == S_TPULSE) begin
            for (int k = 0; k < N_TRIG; k++)
                if (chan_q == 4'(k)) trig_out[k*DATA_W +: DATA_W] = pay_q;
        end
    end

    assign wire_out    = wire_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_FIN);
    assign cmd_count   = count_q;
    assign wr_rejected = rej_q;
endmodule

// File: doc/ep_script_player.md
# ep_script_player

Synthesizable, parametrised sequencer that plays a stored script of host-endpoint writes (wire-in updates, trigger-in pulses, timed waits) into the sensor top level. It generalises the wire/trigger stimulus sequences used on the bench to N wire channels and M trigger channels, with configurable settle and pulse-guard timing and optional looping. It sits between the Opal Kelly endpoint fabric (or an on-board self-test source) and `main`, so a sensor acquisition sequence can run without host round-trips.

## Interface
Parameters:
- `N_WIRE`, 6: number of wire-in channels driven.
- `N_TRIG`, 2: number of trigger-in channels driven.
- `DATA_W`, 32: width of each wire/trigger channel and of the command payload.
- `DEPTH`, 16: script buffer entries; power of two, ≥ 2.
- `WIRE_PRE`, 2: idle cycles before a wire update.
- `WIRE_SETTLE`, 6: hold cycles after a wire update.
- `TRIG_PRE`, 5: zero cycles before a trigger pulse.
- `TRIG_POST`, 5: zero cycles after a trigger pulse.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_wr_en`  in  1  append `cmd_wr_data` to the script.
- `cmd_wr_data`  in  2+4+DATA_W  {op[1:0], chan[3:0], payload[DATA_W-1:0]}. op: 0=WIRE, 1=TRIG, 2=WAIT, 3=END.
- `clear`  in  1  empties the script; honoured only in IDLE.
- `start`  in  1  begins playback from entry 0.
- `abort`  in  1  stops playback immediately.
- `loop_en`  in  1  on reaching END or the end of the script, restart at entry 0 instead of finishing.
- `wire_out`  out  N_WIRE*DATA_W  channel k is at `[k*DATA_W +: DATA_W]`.
- `trig_out`  out  N_TRIG*DATA_W  trigger masks, same packing.
- `busy`  out  1  high while not in IDLE.
- `done`  out  1  one-cycle pulse on normal completion.
- `cmd_count`  out  $clog2(DEPTH)+1  number of stored entries.
- `wr_rejected`  out  1  sticky; set by a rejected write; cleared by `clear` or `reset`.

## Operation
- States: IDLE, FETCH, WPRE, WSET, TPRE, TPULSE, TPOST, WAIT, FIN.
- Write rule: `cmd_wr_en` is accepted only in IDLE when `cmd_count < DEPTH`. Otherwise the write is dropped and `wr_rejected` is set.
- IDLE: `start` sets rd_ptr=0 and enters FETCH. A `start` while busy is ignored.
- FETCH (1 cycle): if rd_ptr == `cmd_count` or op is END, go to FIN, or to FETCH with rd_ptr=0 when `loop_en`=1 and `cmd_count`>0. Otherwise decode the entry and advance rd_ptr.
- WIRE: WPRE lasts WIRE_PRE cycles. On exit, `wire_out[chan]` is set to payload. WSET lasts WIRE_SETTLE cycles, then FETCH.
- TRIG: TPRE lasts TRIG_PRE cycles. TPULSE lasts 1 cycle with `trig_out[chan]`=payload and all other channels 0. TPOST lasts TRIG_POST cycles, then FETCH. `trig_out` is 0 in every state except TPULSE.
- WAIT: stays in WAIT for payload cycles, then FETCH. Payload 0 goes straight to FETCH.
- Out-of-range chan (≥ N_WIRE for WIRE, ≥ N_TRIG for TRIG): the entry is a no-op and costs only the FETCH cycle.
- FIN (1 cycle): `done`=1, then IDLE.
- `abort`: highest priority. Next state is IDLE, `trig_out` is forced to 0, `wire_out` holds, and `done` is not pulsed. Script contents are kept.
- `clear` in IDLE: `cmd_count`=0 and `wr_rejected`=0. Simultaneous `clear` and `start`: `clear` wins and playback finishes with an empty script.
- Empty script plus `start`: FETCH, then FIN, so `done` pulses 2 cycles after `start`. No output changes.

## Timing
- Reset values: `wire_out`=0, `trig_out`=0, `busy`=0, `done`=0, `cmd_count`=0, `wr_rejected`=0, state IDLE. Script RAM contents are don't-care.
- Reset asserted mid-playback returns every output to its reset value on the next edge.
- Edge E0 is the edge that samples `start`. `busy` rises after E0. FETCH of entry 0 occupies cycle E0→E1.
- Per-entry duration including FETCH:
  - WIRE: 1+WIRE_PRE+WIRE_SETTLE (9 cycles at defaults).
  - TRIG: 1+TRIG_PRE+1+TRIG_POST (12 cycles at defaults).
  - WAIT n: 1+n.
  - END: 1, then FIN 1.
- For a first-entry WIRE, `wire_out` updates at edge E0+1+WIRE_PRE.
- For a first-entry TRIG, `trig_out` is nonzero for exactly the cycle after edge E0+1+TRIG_PRE.
- A loop restart adds exactly one FETCH cycle (for END) or zero extra cycles (for end of script) beyond the normal FETCH.

## Test plan
- Reset release, then write {WIRE ch0 1}, {WIRE ch0 0}, {WIRE ch5 5}, {END} and `start` → `cmd_count`=4. `wire_out[0]` goes 1 at E0+3 and 0 at E0+12. `wire_out[5]`=5 at E0+21. `done` pulses after 28 cycles total. `busy` falls with `done`.
- Script {TRIG ch1 0x1}, {WAIT 24300}, {TRIG ch1 0x1}, {END} → `trig_out[1]`=1 for exactly one cycle at each TRIG. Pulse separation is 1+5+1+5 + 1+24300 = 24313 cycles.
- Write 17 entries with DEPTH=16 → `cmd_count`=16 and `wr_rejected`=1. A write while `busy` is also rejected. `clear` returns both to 0.
- `loop_en`=1 with script {TRIG ch0 0x3}, no END → a pulse of 0x3 every 12 cycles, `done` never pulses. `abort` mid-TPULSE → `trig_out`=0 on the next edge, IDLE, no `done`.
- Corner cases:
  - WIRE ch9 and TRIG ch4 at defaults: no output change, 1 cycle each.
  - `start` with an empty script: `done` pulses 2 cycles after `start`.
  - Simultaneous `clear` and `start`: empty run.
  - `reset` mid-WSET: all outputs 0.
